// File: rtl/channel_mixer_if.sv
// Sample-in / mixed-sample-out handshake bundle for channel_mixer.
interface channel_mixer_if;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic               channel_last;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               out_ready;

  modport master (
    output sample_valid, sample_in, channel_last, out_ready,
    input  out_valid, out_sample
  );

  modport slave (
    input  sample_valid, sample_in, channel_last, out_ready,
    output out_valid, out_sample
  );
endinterface

// File: rtl/channel_mixer.sv
// Sums one frame of channel samples, applies Q7 master volume, saturates to Q15.
// Optional CHANNEL_MIXER_PEAK_EN adds a peak-magnitude output port.
module channel_mixer #(
  parameter int CHANNELS = 16,
  parameter int ACC_W    = 16 + $clog2(CHANNELS)
) (
  input  logic               clock,
  input  logic               reset,
  channel_mixer_if.slave     mi,
  input  logic [7:0]         volume,
  output logic               clip,
  output logic               overrun,
  output logic               frame_err,
  input  logic               flag_clear
`ifdef CHANNEL_MIXER_PEAK_EN
  ,
  output logic [15:0]        peak
`endif
);

  localparam int CNT_W  = $clog2(CHANNELS + 1);
  localparam int PROD_W = ACC_W + 9;
  localparam logic signed [PROD_W-1:0] MAX_S = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] MIN_S = -PROD_W'(32768);

  typedef enum logic {ACCUM, SCALE} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum_reg;
  logic [CNT_W-1:0]          count;
  logic                      first;

  logic                      at_limit;
  logic                      take;
  logic                      close;
  logic                      extra;
  logic signed [ACC_W-1:0]   total;
  logic signed [PROD_W-1:0]  sum_x;
  logic signed [PROD_W-1:0]  vol_x;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  scaled;
  logic                      sat;
  logic signed [15:0]        result;
  logic                      out_free;
  logic                      load;

  // A frame that has already hit CHANNELS samples only admits its closing sample.
  assign at_limit = (count == CNT_W'(CHANNELS));
  assign take     = mi.sample_valid && (!at_limit || mi.channel_last);
  assign close    = take && mi.channel_last;
  assign extra    = mi.sample_valid && at_limit && !mi.channel_last;
  assign total    = (first ? '0 : acc) + {{(ACC_W-16){mi.sample_in[15]}}, mi.sample_in};

  assign sum_x  = {{9{sum_reg[ACC_W-1]}}, sum_reg};
  assign vol_x  = {{(PROD_W-8){1'b0}}, volume};
  assign prod   = sum_x * vol_x;
  assign scaled = prod >>> 7;

  always_comb begin
    sat    = 1'b0;
    result = scaled[15:0];
    if (scaled > MAX_S) begin
      sat    = 1'b1;
      result = 16'sh7FFF;
    end else if (scaled < MIN_S) begin
      sat    = 1'b1;
      result = -16'sh8000;
    end
  end

  assign out_free = !mi.out_valid || mi.out_ready;
  assign load     = (state == SCALE) && out_free;

`ifdef CHANNEL_MIXER_PEAK_EN
  logic [15:0] res_abs;
  // Two's-complement negate of -32768 yields 0x8000, which reads as 32768 unsigned.
  assign res_abs = result[15] ? (~result + 16'd1) : result;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ACCUM;
      acc           <= '0;
      sum_reg       <= '0;
      count         <= '0;
      first         <= 1'b1;
      mi.out_valid  <= 1'b0;
      mi.out_sample <= '0;
      clip          <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
`ifdef CHANNEL_MIXER_PEAK_EN
      peak          <= '0;
`endif
    end else begin
      if (take) begin
        acc   <= total;
        count <= close ? '0 : count + 1'b1;
        first <= close;
        if (close) sum_reg <= total;
      end
      // A closing sample during SCALE is fine: sum_reg was consumed this cycle.
      state <= close ? SCALE : ACCUM;

      if (load) begin
        mi.out_sample <= result;
        mi.out_valid  <= 1'b1;
      end else if (mi.out_valid && mi.out_ready) begin
        mi.out_valid  <= 1'b0;
      end

      clip      <= !flag_clear && (clip || ((state == SCALE) && sat));
      overrun   <= !flag_clear && (overrun || ((state == SCALE) && !out_free));
      frame_err <= !flag_clear && (frame_err || extra);
`ifdef CHANNEL_MIXER_PEAK_EN
      if (load) begin
        if (flag_clear || res_abs > peak) peak <= res_abs;
      end else if (flag_clear) begin
        peak <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_channel_mixer.sv
// Directed and randomized checks of channel_mixer against a frame-level arithmetic model.
module tb_channel_mixer;
  logic       clock;
  logic       reset;
  logic [7:0] volume;
  logic       clip, overrun, frame_err, flag_clear;
`ifdef CHANNEL_MIXER_PEAK_EN
  logic [15:0] peak;
`endif

  channel_mixer_if mi ();

  channel_mixer #(.CHANNELS(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .mi        (mi),
    .volume    (volume),
    .clip      (clip),
    .overrun   (overrun),
    .frame_err (frame_err),
    .flag_clear(flag_clear)
`ifdef CHANNEL_MIXER_PEAK_EN
    ,
    .peak      (peak)
`endif
  );

  int checks = 0;
  int errors = 0;
  int got[$];
  int exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Every handshake the consumer completes, seen mid-cycle.
  always @(negedge clock)
    if (!reset && mi.out_valid && mi.out_ready) got.push_back(int'(mi.out_sample));

  // Frame total -> output: floor(sum*vol/128), clamped to Q15.
  function automatic int mix(input longint sum, input int vol);
    longint p, q;
    p = sum * vol;
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return int'(q);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int v, input bit last);
    mi.sample_valid = 1'b1;
    mi.sample_in    = v[15:0];
    mi.channel_last = last;
    tick(1);
    mi.sample_valid = 1'b0;
    mi.channel_last = 1'b0;
  endtask

  task automatic send_const(input int n, input int v);
    for (int i = 0; i < n; i++) send(v, i == n - 1);
  endtask

  task automatic expect_out(input string tag, input int exp);
    int n;
    n = 0;
    while (got.size() == 0 && n < 20) begin
      tick(1);
      n++;
    end
    if (got.size() == 0) check({tag, "_timeout"}, got.size(), 1);
    else check(tag, got.pop_front(), exp);
  endtask

  task automatic pulse_clear();
    flag_clear = 1'b1;
    tick(1);
    flag_clear = 1'b0;
  endtask

  initial begin
    int vol, n, gap, v;
    longint sum;

    reset = 1'b1;
    volume = 8'd128;
    flag_clear = 1'b0;
    mi.sample_valid = 1'b0;
    mi.sample_in = '0;
    mi.channel_last = 1'b0;
    mi.out_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_out_valid", int'(mi.out_valid), 0);
    check("rst_out_sample", int'(mi.out_sample), 0);
    check("rst_clip", int'(clip), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_frame_err", int'(frame_err), 0);

    // Latency: last sample at N, SCALE at N+1, out_valid at N+2 for one cycle.
    send(1000, 0); send(2000, 0); send(-500, 0); send(100, 1);
    check("lat_n1_valid", int'(mi.out_valid), 0);
    tick(1);
    check("lat_n2_valid", int'(mi.out_valid), 1);
    check("lat_n2_sample", int'(mi.out_sample), mix(2600, 128));
    tick(1);
    check("lat_n3_valid", int'(mi.out_valid), 0);
    expect_out("basic_sum", 2600);
    check("basic_clip", int'(clip), 0);

    // Saturation both ways, then clear.
    send_const(16, 30000);
    expect_out("sat_hi", mix(16 * 30000, 128));
    check("sat_hi_clip", int'(clip), 1);
    send_const(16, -30000);
    expect_out("sat_lo", -32768);
    pulse_clear();
    check("clip_cleared", int'(clip), 0);

    // Volume scaling and floor rounding.
    volume = 8'd64;  send_const(3, 1000); expect_out("vol64", 1500);
    volume = 8'd255; send_const(3, 1000); expect_out("vol255", 5976);
    send(999, 0); send(1000, 0); send(1000, 1); expect_out("vol255_2999", 5974);
    volume = 8'd0;   send_const(3, 1000); expect_out("vol0", 0);
    volume = 8'd64;  send(-1, 0); send(-2, 1); expect_out("floor_neg", -2);
    volume = 8'd128;
    check("no_overrun_yet", int'(overrun), 0);

    // Back-pressure: first result held, second dropped.
    mi.out_ready = 1'b0;
    send(111, 1);
    tick(2);
    check("hold_valid", int'(mi.out_valid), 1);
    send(222, 1);
    tick(2);
    check("hold_sample", int'(mi.out_sample), 111);
    check("overrun_set", int'(overrun), 1);
    mi.out_ready = 1'b1;
    tick(1);
    check("drain_valid", int'(mi.out_valid), 0);
    expect_out("held_value", 111);
    tick(3);
    check("dropped_none", got.size(), 0);
    pulse_clear();
    check("overrun_cleared", int'(overrun), 0);

    // Over-long frame: 17th sample ignored, closing sample still counted.
    for (int i = 0; i < 17; i++) send(100, 0);
    send(5, 1);
    check("frame_err_set", int'(frame_err), 1);
    expect_out("long_frame", 1605);
    pulse_clear();
    check("frame_err_cleared", int'(frame_err), 0);

    // Reset mid-frame discards the partial sum.
    send(700, 0); send(700, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    send(10, 0); send(20, 1);
    expect_out("after_reset", 30);

    // Next frame starts during SCALE; back-to-back single-sample frames.
    send(1, 0); send(2, 1); send(40, 0); send(50, 1);
    expect_out("b2b_a", 3);
    expect_out("b2b_b", 90);
    send(7, 1); send(-9, 1);
    expect_out("single_a", 7);
    expect_out("single_b", -9);

`ifdef CHANNEL_MIXER_PEAK_EN
    pulse_clear();
    send(100, 1); expect_out("peak_a", 100);
    send(-32768, 1); expect_out("peak_b", -32768);
    send(50, 1); expect_out("peak_c", 50);
    tick(1);
    check("peak_value", int'(peak), 32768);
`endif

    // Randomized frames; volume only changes after an idle gap past SCALE.
    vol = 128;
    volume = 8'd128;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(16, 1);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        v = int'($urandom_range(65535, 0)) - 32768;
        sum += v;
        send(v, i == n - 1);
      end
      exp_q.push_back(mix(sum, vol));
      gap = $urandom_range(2, 0);
      if (gap > 0) begin
        tick(gap);
        vol = $urandom_range(255, 0);
        volume = vol[7:0];
      end
    end
    while (exp_q.size() > 0) expect_out("random_frame", exp_q.pop_front());
    tick(3);
    check("random_no_extra", got.size(), 0);
    check("random_no_overrun", int'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/channel_mixer.md
Name: channel_mixer

Overview:
- Downstream of the per-channel digital filter.
- Consumes the time-multiplexed stream of filtered 16-bit channel samples, one per channel pass.
- Sums every channel of an audio frame in a wide accumulator, applies master volume, saturates to 16 bits and presents one mixed sample per frame to the codec/output stage over a valid/ready handshake.
- Sits between the synthesiser channel pipeline and the audio codec serialiser.

Parameters:
- CHANNELS, 16, maximum channels per frame; must be ≥2.
- ACC_W, 16+$clog2(CHANNELS), accumulator width (signed); overflow of the raw sum is impossible.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  sample_in valid this cycle (one filter pass output)
- sample_in  in  16  signed Q15 filtered channel sample
- channel_last  in  1  qualifies sample_valid; this sample is the last of the frame
- volume  in  8  unsigned Q7 master gain (128 = unity, 255 ≈ 1.99, 0 = mute); sampled in SCALE
- out_valid  out  1  out_sample holds an unconsumed mixed sample
- out_sample  out  16  signed Q15 mixed, saturated sample
- out_ready  in  1  consumer accepts out_sample when out_valid && out_ready
- clip  out  1  sticky; set when a frame saturated
- overrun  out  1  sticky; set when a completed frame was dropped
- frame_err  out  1  sticky; set when more than CHANNELS samples arrived without channel_last
- flag_clear  in  1  clears clip, overrun, frame_err (and peak, if built)

Behaviour:
- Reset: out_valid=0, out_sample=0, clip=0, overrun=0, frame_err=0. Accumulator=0, channel count=0, FSM=ACCUM, first-of-frame flag=1.
- FSM states are ACCUM and SCALE.
- ACCUM, sample_valid=1:
  - acc <= (first ? 0 : acc) + sext(sample_in); count <= count+1; first <= 0.
  - If channel_last=1: sum_reg <= the same total, first <= 1, count <= 0, go to SCALE.
- SCALE, exactly one cycle:
  - prod = sum_reg * {0,volume} (signed, ACC_W+9 bits); scaled = prod >>> 7 (arithmetic, truncation toward −inf).
  - Saturate to [-32768, 32767]; set clip when saturation occurs.
  - Load the output register if it is free (out_valid=0, or out_valid && out_ready this cycle): out_sample <= result, out_valid <= 1.
  - Otherwise discard the result, set overrun, leave out_sample unchanged.
  - Return to ACCUM.
- A sample_valid arriving during SCALE is accepted as the first sample of the next frame; sum_reg is already captured. No input back-pressure exists.
- Latency: last sample accepted at cycle N → out_valid high at N+2.
- Output handshake:
  - out_sample is stable while out_valid && !out_ready.
  - On out_valid && out_ready with no load in the same cycle, out_valid <= 0.
  - A load in the same cycle as acceptance keeps out_valid=1 with the new data.
- Frame length:
  - A sample arriving when count == CHANNELS with channel_last=0 is ignored (not accumulated) and sets frame_err.
  - A later channel_last still closes the frame; a channel_last sample at count == CHANNELS is accumulated normally.
- A single-sample frame (channel_last on the first sample) is legal.
- Sticky flags: flag_clear has priority over a same-cycle set.
- Reset mid-frame or mid-SCALE discards the partial frame and the pending result; all state returns to reset values on the next edge.

Optional Feature:
- Macro: CHANNEL_MIXER_PEAK_EN.
- Defined: adds output port peak (out, 16) holding the unsigned absolute maximum of all samples loaded into out_sample since reset or flag_clear.
  - |−32768| is reported as 32768.
  - Updated on the cycle after the load.
  - A flag_clear in the same cycle as a load sets peak to that sample's absolute value.
- Undefined: no peak port and no peak logic; all other behaviour identical.

Test Plan:
- Reset, 4-channel frames with samples 1000,2000,−500,100 (last on 4th), volume=128, out_ready=1 → out_sample=2600, out_valid pulses 1 cycle at N+2, clip=0.
- 16 samples of 30000, volume=128 → out_sample=32767, clip=1. Then 16 of −30000 → out_sample=−32768. flag_clear → clip=0.
- Frame 3 samples of 1000, volume=64 → 1500; volume=255 → 5976 (2999×255>>>7 check with sum 2999 → 5974); volume=0 → 0; sum −3, volume=64 → −2 (floor).
- out_ready=0, two frames complete → first sample held stable, second dropped, overrun=1. Raise out_ready → first accepted, out_valid=0.
- 17 samples with no channel_last (CHANNELS=16), then channel_last → frame_err=1, 17th sample excluded from sum. Assert reset mid-frame → next frame sums only new samples.
- Back-to-back frames with the next frame's first sample during SCALE → both frames correct. With CHANNEL_MIXER_PEAK_EN, outputs 100, −32768, 50 → peak=32768.
